pll_reset_sequencer: RTL

- Controls the host-core PLL's reset and lock acquisition.
- Runs on the free-running board reference clock, not a PLL output.
- Drives the PLL reset and qualifies its asynchronous locked signal.
- Holds the core reset until lock has been stable, retries failed acquisitions with a timeout, and reports a sticky fault.

---
 rtl/pll_reset_sequencer_pkg.sv | 19 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_ASSERT,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  localparam logic [7:0] LOSS_SAT = 8'hFF;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable synchronized lock, then releases the core reset.
// Failed acquisitions retry after a timeout; exhausting the retries latches a sticky fault.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 4,
  localparam int CNT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1),
  localparam int RTY_W = cnt_width(MAX_RETRIES)
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             restart,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fault,
  output logic [RTY_W-1:0] retry_count,
  output logic [7:0]       lock_loss_count
);

  localparam int PULSE_W = cnt_width(RST_PULSE_CYCLES);
  localparam int STAB_W  = cnt_width(LOCK_STABLE_CYCLES);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ACQ_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]   RETRY_MAX  = RTY_W'(MAX_RETRIES);

  state_t             state, state_nxt;
  logic               locked_s;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [CNT_W-1:0]   acq_cnt;
  logic [STAB_W-1:0]  stab_cnt;
  logic               acquiring, stab_done, timeout, retry_ok, run_loss;
  logic               pll_rst_d, sys_rst_d, ready_d, fault_d;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign acquiring = (state == WAIT_LOCK) || (state == STABILIZE);
  assign stab_done = (state == STABILIZE) && locked_s && (stab_cnt == STAB_LAST);
  assign timeout   = acquiring && (acq_cnt == ACQ_LAST);
  assign retry_ok  = retry_count < RETRY_MAX;
  assign run_loss  = (state == RUN) && !locked_s && !restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state <= RESET_ASSERT;
    else        state <= state_nxt;
  end

  // Stability completing wins over a timeout landing on the same cycle.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = RESET_ASSERT;
    end else begin
      case (state)
        RESET_ASSERT: if (pulse_cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (timeout)       state_nxt = retry_ok ? RESET_ASSERT : FAULT;
          else if (locked_s) state_nxt = STABILIZE;
        end
        STABILIZE: begin
          if (stab_done)     state_nxt = RUN;
          else if (timeout)  state_nxt = retry_ok ? RESET_ASSERT : FAULT;
          else if (!locked_s) state_nxt = WAIT_LOCK;
        end
        RUN:     if (!locked_s) state_nxt = RESET_ASSERT;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RESET_ASSERT;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d = 1'b1;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    case (state_nxt)
      WAIT_LOCK, STABILIZE: pll_rst_d = 1'b0;
      RUN: begin
        pll_rst_d = 1'b0;
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      pll_rst <= pll_rst_d;
      sys_rst <= sys_rst_d;
      ready   <= ready_d;
      fault   <= fault_d;
    end
  end

  // Each counter runs only while its phase continues and clears on any exit.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
      acq_cnt   <= '0;
      stab_cnt  <= '0;
    end else begin
      if (state == RESET_ASSERT && state_nxt == RESET_ASSERT && !restart)
        pulse_cnt <= pulse_cnt + 1'b1;
      else
        pulse_cnt <= '0;

      if (acquiring && (state_nxt == WAIT_LOCK || state_nxt == STABILIZE))
        acq_cnt <= acq_cnt + 1'b1;
      else
        acq_cnt <= '0;

      if (state == STABILIZE && state_nxt == STABILIZE)
        stab_cnt <= stab_cnt + 1'b1;
      else
        stab_cnt <= '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      if (restart || run_loss)
        retry_count <= '0;
      else if (timeout && !stab_done && retry_ok)
        retry_count <= retry_count + 1'b1;

      if (run_loss && lock_loss_count != LOSS_SAT)
        lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

endmodule
